// File: rtl/seg7_pkg.sv
// Shared constants, FSM state type and BCD helper for the 7-segment scan driver.
package seg7_pkg;

  localparam int unsigned BIN_W   = 8;
  localparam int unsigned BCD_W   = 12;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned NUM_DIG = 3;
  localparam int unsigned SLOT_W  = 2;
  localparam int unsigned CNT_W   = 3;

  localparam logic [SEG_W-1:0]  SEG_BLANK = 7'h00;

  localparam logic [SLOT_W-1:0] DIG_ONES = 2'd0;
  localparam logic [SLOT_W-1:0] DIG_TENS = 2'd1;
  localparam logic [SLOT_W-1:0] DIG_HUND = 2'd2;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } conv_state_e;

  // Double-dabble correction: a nibble of 5 or more gets 3 added before the shift.
  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? 4'(nib + 4'd3) : nib;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-and-add-3, 8 iterations).
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BIN_W-1:0] value,
  input  logic             load,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  conv_state_e      state_q;
  logic [BIN_W-1:0] bin_q;
  logic [BCD_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;

  logic [BCD_W-1:0]       acc_adj;
  logic [BCD_W+BIN_W-1:0] shifted;

  // One iteration: correct every nibble, then shift {acc, bin} left by one.
  always_comb begin
    acc_adj = {add3(acc_q[11:8]), add3(acc_q[7:4]), add3(acc_q[3:0])};
    shifted = {acc_adj[BCD_W-2:0], bin_q, 1'b0};
  end

  // Converter FSM; bcd holds the last completed result and only moves on done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load) begin
            bin_q   <= value;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          acc_q <= shifted[BCD_W+BIN_W-1:BIN_W];
          bin_q <= shifted[BIN_W-1:0];
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            bcd     <= shifted[BCD_W+BIN_W-1:BIN_W];
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Converts a binary value to BCD and scans it onto a 3-digit common-cathode display.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BIN_W-1:0]   value,
  input  logic               load,
  output logic               busy,
  output logic               done,
  output logic [SEG_W-1:0]   segments,
  output logic [NUM_DIG-1:0] digit_sel
);

  localparam int unsigned      PRE_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

  logic [BCD_W-1:0] bcd;
  logic [3:0]       d2, d1, d0;

  logic [PRE_W-1:0]   pre_q;
  logic [SLOT_W-1:0]  slot_q;
  logic [SLOT_W-1:0]  slot_nxt;
  logic [SEG_W-1:0]   seg_nxt;
  logic [NUM_DIG-1:0] sel_nxt;
  logic               blank_hund;
  logic               blank_tens;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .value (value),
    .load  (load),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  assign d2 = bcd[11:8];
  assign d1 = bcd[7:4];
  assign d0 = bcd[3:0];

  // Digit decoder, segment order {g,f,e,d,c,b,a}; non-decimal codes stay dark.
  function automatic logic [SEG_W-1:0] seg_decode(input logic [3:0] dig);
    case (dig)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Next slot and its segment pattern, including leading-zero blanking.
  always_comb begin
    blank_hund = BLANK_LZ && (d2 == 4'd0);
    blank_tens = BLANK_LZ && (d2 == 4'd0) && (d1 == 4'd0);
    slot_nxt   = (slot_q == DIG_HUND) ? DIG_ONES : SLOT_W'(slot_q + 2'd1);
    sel_nxt    = NUM_DIG'(3'b001 << slot_nxt);
    case (slot_nxt)
      DIG_ONES: seg_nxt = seg_decode(d0);
      DIG_TENS: seg_nxt = blank_tens ? SEG_BLANK : seg_decode(d1);
      DIG_HUND: seg_nxt = blank_hund ? SEG_BLANK : seg_decode(d2);
      default:  seg_nxt = SEG_BLANK;
    endcase
  end

  // Prescaler and slot register; select and segments update together on wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q     <= '0;
      slot_q    <= DIG_ONES;
      digit_sel <= 3'b001;
      segments  <= 7'h3F;
    end else if (pre_q == PRE_LAST) begin
      pre_q     <= '0;
      slot_q    <= slot_nxt;
      digit_sel <= sel_nxt;
      segments  <= seg_nxt;
    end else begin
      pre_q     <= PRE_W'(pre_q + 1'b1);
    end
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Downstream display stage for the 8-bit free-running counter. It takes the counter's binary value and converts it to three BCD digits with a sequential shift-and-add-3 converter. It then drives a multiplexed 3-digit common-cathode 7-segment display, one digit per scan slot. It sits between the counter's `uo_out` value and the board's segment and digit-select pins.

## Interface
Parameters:
- `SCAN_DIV`, default 1000: clock cycles per digit slot; minimum 1.
- `BLANK_LZ`, default 1: 1 = blank leading zeros; 0 = always show three digits.

Ports:
- `clk`  in  1  single system clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `value`  in  8  binary value to display.
- `load`  in  1  request to convert `value`; sampled on rising `clk`.
- `busy`  out  1  conversion in progress; `load` is ignored while high.
- `done`  out  1  one-cycle pulse when new digits are latched.
- `segments`  out  7  `{g,f,e,d,c,b,a}`, active-high, for the currently selected digit.
- `digit_sel`  out  3  one-hot, active-high; bit0 = ones, bit1 = tens, bit2 = hundreds.

## Operation
- Converter FSM has two states, IDLE and SHIFT.
- IDLE: on an edge with `load`=1:
  - shift register <= `value`
  - BCD accumulator <= 0
  - iteration count <= 0
  - `busy` <= 1
  - go to SHIFT.
- SHIFT: each edge does the following, in order:
  - add 3 to every BCD nibble that is >= 5
  - shift `{bcd[11:0], bin[7:0]}` left by 1
  - increment the iteration count.
- On the 8th SHIFT edge (count==7):
  - display registers `d2,d1,d0` <= final BCD
  - `done` <= 1 for one cycle
  - `busy` <= 0
  - return to IDLE.
- `load` in SHIFT is ignored; it is not queued. A `load` on the same edge that returns to IDLE is also ignored.
- Display registers change only on `done`. The scanner always shows the last completed conversion.
- BCD width is 12 bits (3 nibbles). `d2` never exceeds 2 (maximum input 255).
- Scanner:
  - Prescaler counts 0..`SCAN_DIV`-1.
  - At the terminal count it wraps to 0 and the slot index advances 0→1→2→0.
  - `digit_sel` = one-hot of the slot index.
  - `segments` = decode of `d0`/`d1`/`d2` for the selected slot.
- Blanking, when `BLANK_LZ`=1:
  - Hundreds slot is blanked when `d2`==0.
  - Tens slot is blanked when `d2`==0 and `d1`==0.
  - Ones slot is never blanked.
  - A blanked slot drives `segments`=0; `digit_sel` still cycles normally.
- Decode: standard hex 0-9. Codes 10-15 cannot occur; they drive 0.

## Timing
- Reset values:
  - `busy`=0, `done`=0
  - `d2..d0`=0
  - prescaler=0, slot index=0
  - `digit_sel`=3'b001, `segments`=7'h3F ("0" on ones).
- Latency:
  - `load` sampled at edge E0 → `busy` high after E0.
  - `done`=1 and new digits are valid after E8.
  - `busy` low after E8.
  - Next `load` is accepted at E9 at the earliest.
- `segments` and `digit_sel` are registered and change together, on the prescaler wrap edge only. There is never a cycle with mismatched select and segments.
- A new `done` takes effect on displayed segments at the next slot change.
- Reset mid-conversion: conversion is aborted, `d2..d0` are cleared, and no `done` is produced.
- `SCAN_DIV`=1: slot advances every cycle.

## Structure
- Shared package `seg7_pkg`:
  - `SEG_BLANK` = 7'h00
  - digit-index constants `DIG_ONES`/`DIG_TENS`/`DIG_HUND`
  - FSM state typedef `{IDLE, SHIFT}`.
- One sub-module, `bin2bcd_seq`: converter FSM with `value`, `load`, `busy`, `done`, `bcd[11:0]`.
- The top level holds the scanner, blanking logic and the existing 7-segment digit decoder.

## Test plan
- Reset held 3 cycles, then released → `digit_sel`=001, `segments`=7'h3F, `busy`=0, `done`=0.
- `load` with `value`=8'd255 → `busy` high 8 cycles; `done` pulse after E8; `d2,d1,d0`=2,5,5; scan shows 0x5B, 0x6D, 0x6D on selects 100, 010, 001.
- `value`=8'd7, `BLANK_LZ`=1 → ones=0x07, tens and hundreds slots=0x00; with `BLANK_LZ`=0, tens and hundreds=0x3F.
- `load` pulsed at E3 during a conversion of 8'd100 with `value`=8'd9 → ignored; result 1,0,0, exactly one `done`.
- `SCAN_DIV`=4 → each select is held exactly 4 cycles, order 001→010→100→001, across 3 full rotations.
- `rst_n` low at E4 of a conversion → next cycle `busy`=0, digits=0, no `done`; a fresh `load` of 8'd42 gives 0,4,2.
